// File: rtl/clock_set_controller_if.sv
// Signal bundle between the clock-set controller and the sec/min/hour counter chain.
interface clock_set_controller_if;
  logic       tick;
  logic       mode_btn;
  logic       inc_held;
  logic       sec_carry;
  logic       min_carry;
  logic       sec_in;
  logic       min_in;
  logic       hr_in;
  logic [1:0] mode;
  logic       blink;

  modport master (
    input  tick, mode_btn, inc_held, sec_carry, min_carry,
    output sec_in, min_in, hr_in, mode, blink
  );

  modport slave (
    output tick, mode_btn, inc_held, sec_carry, min_carry,
    input  sec_in, min_in, hr_in, mode, blink
  );
endinterface

// File: rtl/clock_set_controller.sv
// Mode/set sequencer for the digital clock: forwards tick/carries in RUN, steers
// increment pulses (press + auto-repeat) to one counter in SET modes.
module clock_set_controller #(
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned RPT_CYC    = 10_000_000,
  parameter int unsigned TIMEOUT_S  = 10,
  parameter int unsigned BLINK_HALF = 25_000_000
) (
  input  logic                   clk,
  input  logic                   clr,
  clock_set_controller_if.master bus
);

  localparam int unsigned HW = $clog2(HOLD_CYC + 1);
  localparam int unsigned RW = $clog2(RPT_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_S + 1);
  localparam int unsigned BW = $clog2(BLINK_HALF + 1);

  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYC);
  localparam logic [RW-1:0] RPT_LOAD   = RW'(RPT_CYC - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_S - 1);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_S);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } mode_t;

  mode_t          mode_q;
  mode_t          mode_nx;
  logic           held_q;
  logic           inc_pulse;
  logic           inc_fire;
  logic           to_hit;
  logic           blink_q;
  logic [HW-1:0]  hold_cnt;
  logic [RW-1:0]  rpt_cnt;
  logic [TW-1:0]  to_cnt;
  logic [BW-1:0]  blink_cnt;

  // A mode press in the same cycle suppresses any increment that would fire.
  always_comb begin
    inc_fire = 1'b0;
    if (mode_q != RUN && bus.inc_held && !bus.mode_btn) begin
      if (!held_q)
        inc_fire = 1'b1;
      else if (hold_cnt == HOLD_MAX && rpt_cnt == '0)
        inc_fire = 1'b1;
    end
  end

  assign to_hit = (mode_q != RUN) && bus.tick && (to_cnt == TO_LAST) && !inc_fire;

  always_comb begin
    mode_nx = mode_q;
    if (bus.mode_btn) begin
      case (mode_q)
        RUN:     mode_nx = SET_HR;
        SET_HR:  mode_nx = SET_MIN;
        SET_MIN: mode_nx = SET_SEC;
        default: mode_nx = RUN;
      endcase
    end else if (to_hit) begin
      mode_nx = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      mode_q    <= RUN;
      held_q    <= 1'b0;
      inc_pulse <= 1'b0;
      hold_cnt  <= '0;
      rpt_cnt   <= '0;
      to_cnt    <= '0;
      blink_q   <= 1'b0;
      blink_cnt <= '0;
    end else begin
      mode_q    <= mode_nx;
      held_q    <= bus.inc_held;
      inc_pulse <= inc_fire;

      // Hold phase counts up to HOLD_MAX; repeat phase reloads a down-counter.
      if (mode_q == RUN || !bus.inc_held || bus.mode_btn) begin
        hold_cnt <= '0;
        rpt_cnt  <= '0;
      end else if (!held_q) begin
        hold_cnt <= HW'(1);
        rpt_cnt  <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + HW'(1);
      end else if (rpt_cnt == '0) begin
        rpt_cnt <= RPT_LOAD;
      end else begin
        rpt_cnt <= rpt_cnt - RW'(1);
      end

      if (mode_q == RUN || bus.mode_btn || inc_fire)
        to_cnt <= '0;
      else if (bus.tick && to_cnt != TO_MAX)
        to_cnt <= to_cnt + TW'(1);

      if (mode_nx == RUN) begin
        blink_q   <= 1'b0;
        blink_cnt <= '0;
      end else if (mode_nx != mode_q || inc_fire) begin
        blink_q   <= 1'b1;
        blink_cnt <= '0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_q   <= ~blink_q;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    bus.sec_in = 1'b0;
    bus.min_in = 1'b0;
    bus.hr_in  = 1'b0;
    case (mode_q)
      RUN: begin
        bus.sec_in = bus.tick;
        bus.min_in = bus.sec_carry;
        bus.hr_in  = bus.min_carry;
      end
      SET_HR:  bus.hr_in  = inc_pulse;
      SET_MIN: bus.min_in = inc_pulse;
      default: bus.sec_in = inc_pulse;
    endcase
  end

  assign bus.mode  = mode_q;
  assign bus.blink = blink_q;

endmodule
